apb_fsm_controller: RTL
=======================

// Module: apb_fsm_controller
// PURPOSE
//  - Bridge-side sequencer directly upstream of APB_Interface.
//  - Takes pipelined AHB transfer info (valid/addr/write/sel/wdata) and produces the APB SETUP/ACCESS
//    sequence: Pwrite, Penable, Pselx, Paddr, Pwdata.
//  - Stalls AHB via Hreadyout and returns Prdata to AHB as Hrdata.
// PARAMETERS
//  ADDR_W  32  address width (Haddr/Paddr)
//  DATA_W  32  data width (Hwdata/Pwdata/Prdata/Hrdata)
//  NSEL     3  number of APB slaves; width of Hselx/Pselx, one-hot
// PORTS
//  Hclk       in   1       clock; all state changes on rising edge
//  Hreset     in   1       synchronous, active-high reset
//  valid      in   1       AHB address phase of a valid NONSEQ/SEQ transfer this cycle
//  Haddr      in   ADDR_W  AHB address, qualified by valid
//  Hwrite     in   1       1 = write, 0 = read, qualified by valid
//  Hselx      in   NSEL    decoded one-hot slave select, qualified by valid
//  Hwdata     in   DATA_W  AHB write data, valid in the cycle after a write address phase
//  Prdata     in   DATA_W  read data from APB slave, sampled in ACCESS
//  Pready     in   1       APB slave ready (present only with APB_PREADY_EN)
//  Pwrite     out  1       APB direction
//  Penable    out  1       APB enable (ACCESS phase)
//  Pselx      out  NSEL    APB select, one-hot
//  Paddr      out  ADDR_W  APB address
//  Pwdata     out  DATA_W  APB write data
//  Hreadyout  out  1       AHB ready; 0 stalls the master
//  Hrdata     out  DATA_W  Prdata when state==ACCESS && !Pwrite, else 0 (combinational)
//  Hresp      out  2       tied 2'b00 (OKAY)
// BEHAVIOUR
//  - Reset (sync, Hreset=1): state=IDLE; Pwrite=0, Penable=0, Pselx=0, Paddr=0, Pwdata=0, Hreadyout=1.
//    Overrides any in-flight transfer; no partial APB cycle continues.
//  - All P* outputs and Hreadyout are registered (Moore). Addr/sel/write are captured on the accepting edge.
//  - "accept" = valid && |Hselx && Hreadyout. If valid but Hselx==0: no capture, state unchanged.
//  - States:
//    - IDLE: Hreadyout=1, Pselx=0, Penable=0.
//      - accept & Hwrite  -> WWAIT
//      - accept & !Hwrite -> SETUP
//      - else stay IDLE
//    - WWAIT: Hreadyout=0; capture Hwdata into Pwdata on exit; -> SETUP.
//    - SETUP: Pselx=captured sel, Penable=0, Paddr/Pwrite driven; Hreadyout=0; -> ACCESS.
//    - ACCESS: Penable=1, Pselx/Paddr/Pwrite/Pwdata held.
//      - Hreadyout=1 in this cycle (AHB data phase completes; Hrdata valid for reads).
//      - accept & Hwrite -> WWAIT; accept & !Hwrite -> SETUP (back-to-back); else IDLE.
//      - On exit to IDLE: Pselx=0, Penable=0. Paddr/Pwdata/Pwrite hold their last values.
//  - Latency, valid at edge T:
//    - read:  SETUP at T+1, ACCESS at T+2 (Hreadyout=1 at T+2).
//    - write: WWAIT at T+1, SETUP at T+2, ACCESS at T+3.
//  - Back-to-back: no idle cycle between ACCESS and the next SETUP/WWAIT; Penable drops to 0 in SETUP.
//  - Pselx is never non-zero outside SETUP/ACCESS. Penable=1 only in ACCESS.
//  - Non-one-hot Hselx is captured as-is (the decoder guarantees one-hot).
// CONFIGURATION
//  APB_PREADY_EN defined:
//    - Pready port exists. ACCESS holds (Hreadyout=0, outputs stable, accept disabled) while Pready=0.
//    - Hreadyout=1 and exit only in the ACCESS cycle with Pready=1.
//    - Reset during wait states -> IDLE.
//  APB_PREADY_EN undefined:
//    - no Pready port; ACCESS always lasts exactly 1 cycle (zero-wait APB).
// TESTING
//  1. Reset: Hreset=1 for 2 clk mid-ACCESS -> next edge IDLE, Pselx=0, Penable=0, Paddr=0, Hreadyout=1.
//  2. Read: valid=1, Hwrite=0, Haddr=32'hAAAA_AAAA, Hselx=3'b001, Prdata=32'h1234_5678
//     -> T+1 Pselx=001, Penable=0; T+2 Penable=1, Hreadyout=1, Hrdata=32'h1234_5678; T+3 IDLE.
//  3. Write: valid=1, Hwrite=1, Haddr=32'hBBBB_BBBB, Hselx=3'b010; Hwdata=32'h8765_4321 at T+1
//     -> T+3 Penable=1, Pwrite=1, Pwdata=32'h8765_4321, Hrdata=0.
//  4. Back-to-back read then write (valid high in ACCESS, Haddr=32'hCCCC_CCCC, Hselx=3'b100)
//     -> ACCESS->WWAIT with no IDLE; Penable=0 in WWAIT/SETUP; second ACCESS Paddr=32'hCCCC_CCCC.
//  5. valid=1 with Hselx=3'b000 in IDLE -> stays IDLE, Pselx=0, Hreadyout=1, no capture.
//  6. APB_PREADY_EN: Pready=0 for 3 cycles in ACCESS -> Penable=1, Hreadyout=0 held for 3 cycles;
//     Pready=1 -> Hreadyout=1, exit.

Source files
------------

// File: rtl/apb_fsm_controller.sv
// rtl/apb_fsm_controller.sv - AHB-to-APB sequencer producing SETUP/ACCESS cycles
// Optional APB wait-state support is enabled by defining APB_PREADY_EN.
module apb_fsm_controller #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSEL   = 3
) (
    input  logic              Hclk,
    input  logic              Hreset,
    input  logic              valid,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic              Hwrite,
    input  logic [NSEL-1:0]   Hselx,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic [DATA_W-1:0] Prdata,
`ifdef APB_PREADY_EN
    input  logic              Pready,
`endif
    output logic              Pwrite,
    output logic              Penable,
    output logic [NSEL-1:0]   Pselx,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    output logic              Hreadyout,
    output logic [DATA_W-1:0] Hrdata,
    output logic [1:0]        Hresp
);

    typedef enum logic [1:0] {IDLE, WWAIT, SETUP, ACCESS} state_t;

    state_t          state;
    logic            ready_q;
    logic [NSEL-1:0] sel_q;
    logic            access_done;
    logic            accept;

`ifdef APB_PREADY_EN
    // A slave wait state in ACCESS must stall AHB in the same cycle it is signalled.
    assign access_done = (state != ACCESS) || Pready;
`else
    assign access_done = 1'b1;
`endif

    assign Hreadyout = ready_q && access_done;
    assign accept    = valid && (|Hselx) && Hreadyout;
    assign Hrdata    = (state == ACCESS && !Pwrite) ? Prdata : '0;
    assign Hresp     = 2'b00;

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state   <= IDLE;
            Pwrite  <= 1'b0;
            Penable <= 1'b0;
            Pselx   <= '0;
            Paddr   <= '0;
            Pwdata  <= '0;
            ready_q <= 1'b1;
            sel_q   <= '0;
        end else begin
            case (state)
                IDLE, ACCESS: begin
                    if (state == IDLE || access_done) begin
                        Penable <= 1'b0;
                        Pselx   <= (accept && !Hwrite) ? Hselx : '0;
                        if (accept) begin
                            Paddr   <= Haddr;
                            Pwrite  <= Hwrite;
                            sel_q   <= Hselx;
                            ready_q <= 1'b0;
                            state   <= Hwrite ? WWAIT : SETUP;
                        end else begin
                            state   <= IDLE;
                        end
                    end
                end
                WWAIT: begin
                    // Write data arrives one cycle after its address phase.
                    Pwdata <= Hwdata;
                    Pselx  <= sel_q;
                    state  <= SETUP;
                end
                SETUP: begin
                    Penable <= 1'b1;
                    ready_q <= 1'b1;
                    state   <= ACCESS;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
